// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU control sequencer.
// Op encodings, FSM states and default widths.
package alu_ctrl_pkg;

   localparam int W_DEF  = 16;
   localparam int FW_DEF = 7;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_SUB  = 2'b01,
      ALU_MUL  = 2'b10,
      ALU_NAND = 2'b11
   } alu_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_EXEC,
      S_RESP
   } state_e;

endpackage

// File: rtl/alu_ctrl_if.sv
// Command, response and ALU-side signals of the sequencer.
// slave = the sequencer, master = host plus ALU.
interface alu_ctrl_if
   import alu_ctrl_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int FW = FW_DEF
);

   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [W-1:0]  cmd_a;
   logic [W-1:0]  cmd_b;
   logic          cmd_chain;
   logic [W-1:0]  bus_out;
   logic          bus_oe;
   logic          alu_ai;
   logic          alu_bi;
   logic          alu_oe;
   logic [1:0]    alu_sel;
   logic [W-1:0]  alu_out;
   logic [FW-1:0] alu_flags;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_data;
   logic [FW-1:0] rsp_flags;
   logic [15:0]   op_count;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
      input  alu_out, alu_flags, rsp_ready,
      output cmd_ready, bus_out, bus_oe,
      output alu_ai, alu_bi, alu_oe, alu_sel,
      output rsp_valid, rsp_data, rsp_flags, op_count
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
      output alu_out, alu_flags, rsp_ready,
      input  cmd_ready, bus_out, bus_oe,
      input  alu_ai, alu_bi, alu_oe, alu_sel,
      input  rsp_valid, rsp_data, rsp_flags, op_count
   );

endinterface

// File: rtl/alu_ctrl.sv
// Initiator-side sequencer for the ALU: loads A/B over the shared
// bus, enables the ALU output and holds the result for downstream.
module alu_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int FW = FW_DEF
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_ctrl_if.slave io
);

   state_e        state_q, state_d;
   alu_op_e       op_q, op_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  prev_q, prev_d;
   logic          prev_vld_q, prev_vld_d;
   logic [W-1:0]  rsp_data_q, rsp_data_d;
   logic [FW-1:0] rsp_flags_q, rsp_flags_d;
   logic [15:0]   op_count_q, op_count_d;

   logic          cmd_ready_q, cmd_ready_d;
   logic          bus_oe_q, bus_oe_d;
   logic [W-1:0]  bus_out_q, bus_out_d;
   logic          alu_ai_q, alu_ai_d;
   logic          alu_bi_q, alu_bi_d;
   logic          alu_oe_q, alu_oe_d;
   logic [1:0]    alu_sel_q, alu_sel_d;
   logic          rsp_valid_q, rsp_valid_d;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      prev_d      = prev_q;
      prev_vld_d  = prev_vld_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      op_count_d  = op_count_q;
      unique case (state_q)
         S_IDLE: begin
            if (io.cmd_valid && cmd_ready_q) begin
               op_d = alu_op_e'(io.cmd_op);
               a_d  = io.cmd_a;
               b_d  = io.cmd_b;
               // ALU A still holds the last result
               state_d = (io.cmd_chain && prev_vld_q)
                       ? S_LOAD_B : S_LOAD_A;
            end
         end
         S_LOAD_A: state_d = S_LOAD_B;
         S_LOAD_B: state_d = S_EXEC;
         S_EXEC: begin
            rsp_data_d  = io.alu_out;
            rsp_flags_d = io.alu_flags;
            prev_d      = io.alu_out;
            prev_vld_d  = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (io.rsp_ready) begin
               state_d    = S_IDLE;
               op_count_d = op_count_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are flops decoded from the next state.
   always_comb begin
      cmd_ready_d = (state_d == S_IDLE);
      bus_oe_d    = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
      alu_ai_d    = (state_d == S_LOAD_A);
      alu_bi_d    = (state_d == S_LOAD_B);
      alu_oe_d    = (state_d == S_EXEC);
      rsp_valid_d = (state_d == S_RESP);
      alu_sel_d   = (state_d == S_IDLE) ? 2'b00 : op_d;
      bus_out_d   = '0;
      if (state_d == S_LOAD_A) bus_out_d = a_d;
      if (state_d == S_LOAD_B) bus_out_d = b_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= ALU_ADD;
         a_q         <= '0;
         b_q         <= '0;
         prev_q      <= '0;
         prev_vld_q  <= 1'b0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
         op_count_q  <= '0;
         cmd_ready_q <= 1'b1;
         bus_oe_q    <= 1'b0;
         bus_out_q   <= '0;
         alu_ai_q    <= 1'b0;
         alu_bi_q    <= 1'b0;
         alu_oe_q    <= 1'b0;
         alu_sel_q   <= 2'b00;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         prev_q      <= prev_d;
         prev_vld_q  <= prev_vld_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         op_count_q  <= op_count_d;
         cmd_ready_q <= cmd_ready_d;
         bus_oe_q    <= bus_oe_d;
         bus_out_q   <= bus_out_d;
         alu_ai_q    <= alu_ai_d;
         alu_bi_q    <= alu_bi_d;
         alu_oe_q    <= alu_oe_d;
         alu_sel_q   <= alu_sel_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign io.cmd_ready = cmd_ready_q;
   assign io.bus_oe    = bus_oe_q;
   assign io.bus_out   = bus_out_q;
   assign io.alu_ai    = alu_ai_q;
   assign io.alu_bi    = alu_bi_q;
   assign io.alu_oe    = alu_oe_q;
   assign io.alu_sel   = alu_sel_q;
   assign io.rsp_valid = rsp_valid_q;
   assign io.rsp_data  = rsp_data_q;
   assign io.rsp_flags = rsp_flags_q;
   assign io.op_count  = op_count_q;

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
Initiator-side sequencer for the 16-bit ALU's control interface (ai, bi, oe, sel).
- Accepts an operation command over a valid/ready handshake.
- Drives the operands onto the shared 16-bit data bus and strobes the ALU's A and B load enables.
- Enables the ALU output, then captures result and flags into a response register held until downstream accepts it.
- Sits between the CPU control unit / test host and the ALU; it is the only agent allowed to assert ALU load/output enables.

Parameters:
- W, 16, datapath width; must equal ALU operand width.
- FW, 7, ALU flag vector width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  ALU select: 00 add, 01 sub, 10 mul (low W bits), 11 nand.
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- cmd_chain  in  1  use previous captured result as A; skip the A load.
- bus_out  out  W  value driven onto the shared bus.
- bus_oe  out  1  controller drives the bus.
- alu_ai  out  1  ALU A-register load strobe.
- alu_bi  out  1  ALU B-register load strobe.
- alu_oe  out  1  ALU output enable.
- alu_sel  out  2  ALU operation select.
- alu_out  in  W  ALU result (gated by alu_oe).
- alu_flags  in  FW  ALU flags.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  downstream accepts result.
- rsp_data  out  W  captured result.
- rsp_flags  out  FW  captured flags.
- op_count  out  16  completed operations, wraps at 0xFFFF -> 0.

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1; bus_oe, alu_ai, alu_bi, alu_oe, rsp_valid=0; bus_out, alu_sel, rsp_data, rsp_flags, op_count=0. The previous-result register clears to 0 and is marked invalid.
- FSM states are IDLE, LOAD_A, LOAD_B, EXEC, RESP. Outputs are registered, decoded from the state.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/a/b/chain.
  - If chain=1 and the previous result is valid, go to LOAD_B.
  - Otherwise go to LOAD_A. Chain with no valid previous result falls back to LOAD_A using cmd_a.
- LOAD_A (1 cycle): bus_oe=1, bus_out=a, alu_ai=1. Next state LOAD_B.
- LOAD_B (1 cycle): bus_oe=1, bus_out=b, alu_bi=1. Next state EXEC.
- EXEC (1 cycle): bus_oe=0, alu_oe=1, alu_sel=op. At the end of the cycle, capture alu_out into rsp_data and alu_flags into rsp_flags, and store the previous result (marked valid). Next state RESP.
- alu_sel is driven from the latched op in all non-IDLE states, so it is stable before and during EXEC.
- RESP: rsp_valid=1; data and flags are held stable while rsp_ready=0. On rsp_ready, go to IDLE and increment op_count.
- cmd_ready is 0 in every state except IDLE. There is no command pipelining.
- Latency from the accept edge to rsp_valid:
  - 4 cycles unchained.
  - 3 cycles chained.
- Bus exclusivity invariants:
  - bus_oe and alu_oe are never both 1.
  - alu_ai, alu_bi and alu_oe are mutually exclusive.
  - alu_ai and alu_bi only assert while bus_oe=1.
- Reset mid-operation: all strobes drop immediately (async), any in-flight command is discarded, and no response is produced.
- Arithmetic widths are the ALU's responsibility; the controller passes W-bit results unchanged.

Decomposition:
- Package alu_ctrl_pkg:
  - op encodings: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_MUL=2'b10, ALU_NAND=2'b11.
  - FSM state enum.
  - W/FW defaults.
- A single module; no sub-module is needed.
- The bench instantiates the real ALU as the DUT's partner, plus a bus-contention checker.

Test Plan:
- Reset: rst_n=0 mid-LOAD_B -> all strobes 0 within the same cycle; after release cmd_ready=1, rsp_valid=0, op_count=0.
- Add with rsp_ready=1: op=00, a=0x1234, b=0x0101 -> bus_out shows 0x1234 then 0x0101; rsp_valid 4 cycles after accept; rsp_data=0x1335; op_count=1.
- Mul truncation plus backpressure: op=10, a=0x0100, b=0x0100, rsp_ready held 0 for 5 cycles -> rsp_data=0x0000 held stable, cmd_ready=0 throughout, completes when rsp_ready=1.
- Chain: sub a=10, b=3 -> 7; then chain=1, op=00, b=5 -> no alu_ai pulse, latency 3, rsp_data=12.
- Chain with no prior result after reset: chain=1, a=0xFFFF, b=0x0001, op=11 -> LOAD_A occurs, rsp_data=0xFFFE.
- Random ops for 10k commands with random rsp_ready -> results match the reference model, bus/strobe exclusivity never violated, op_count equals accepted responses mod 2^16.
